// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: request record, arbiter states and bram window bounds shared by the arbiter.
package bram_arbiter_pkg;
  localparam logic [31:0] bram_base_addr = 32'h0000_0000;
  localparam logic [31:0] bram_top_addr  = 32'h0010_0000;
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;
  localparam int REQ_W = $bits(mem_req_t);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, LOCAL_I, LOCAL_D} arb_state_t;
  // Offset compare keeps a zero base from degenerating into a constant test.
  function automatic logic in_window(logic [31:0] addr, logic [31:0] base, logic [31:0] top);
    return (addr - base) < (top - base);
  endfunction
endpackage

// File: rtl/bram_arbiter_slot.sv
// bram_arbiter_slot: one-deep request capture register with pending bit.
module bram_arbiter_slot import bram_arbiter_pkg::*; (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [REQ_W-1:0] req,
  input  logic             clear,
  output logic             pending,
  output logic [REQ_W-1:0] req_q
);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      req_q   <= '0;
    end else if (valid && (!pending || clear)) begin
      pending <= 1'b1;
      req_q   <= req;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end
  a_one_outstanding: assert property (@(posedge clock) disable iff (reset) !(valid && pending && !clear))
    else $error("bram_arbiter_slot: request while slot pending, ignored");
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares the bram port between instruction fetch (I) and load/store (D).
// Define BRAM_ARBITER_ROUND_ROBIN_EN for round-robin instead of fixed D-over-I priority.
module bram_arbiter import bram_arbiter_pkg::*; #(
  parameter logic [31:0] BRAM_BASE = bram_base_addr,
  parameter logic [31:0] BRAM_TOP  = bram_top_addr
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);
  arb_state_t       state, state_n;
  mem_req_t         mreq, live_i, live_d, sel_i, sel_d, win;
  logic [REQ_W-1:0] q_i, q_d;
  logic             pend_i, pend_d, done_i, done_d, busy, free;
  logic             elig_i, elig_d, prefer_d, pick_d, grant, in_range;
  assign live_i = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
  assign live_d = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};
  bram_arbiter_slot u_slot_i (.clock, .reset, .valid(imem_valid), .req(live_i), .clear(done_i), .pending(pend_i), .req_q(q_i));
  bram_arbiter_slot u_slot_d (.clock, .reset, .valid(dmem_valid), .req(live_d), .clear(done_d), .pending(pend_d), .req_q(q_d));
  // A completing transaction frees the port in the same cycle, so the next grant needs no idle bubble.
  always_comb begin
    busy       = state == BUSY_I || state == BUSY_D;
    done_i     = (state == BUSY_I && memory_ready) || state == LOCAL_I;
    done_d     = (state == BUSY_D && memory_ready) || state == LOCAL_D;
    imem_ready = done_i;
    dmem_ready = done_d;
    imem_rdata = (state == BUSY_I && memory_ready) ? memory_rdata : '0;
    dmem_rdata = (state == BUSY_D && memory_ready) ? memory_rdata : '0;
    free       = state == IDLE || (busy && memory_ready);
    elig_i     = (pend_i && !done_i) || imem_valid;
    elig_d     = (pend_d && !done_d) || dmem_valid;
    sel_i      = (pend_i && !done_i) ? mem_req_t'(q_i) : live_i;
    sel_d      = (pend_d && !done_d) ? mem_req_t'(q_d) : live_d;
    pick_d     = elig_d && (!elig_i || prefer_d);
    grant      = free && (elig_i || elig_d);
    win        = pick_d ? sel_d : sel_i;
    in_range   = in_window(win.addr, BRAM_BASE, BRAM_TOP);
    state_n    = grant ? (pick_d ? (in_range ? BUSY_D : LOCAL_D) : (in_range ? BUSY_I : LOCAL_I))
               : (free || state == LOCAL_I || state == LOCAL_D) ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      memory_valid <= 1'b0;
      mreq         <= '0;
    end else begin
      state        <= state_n;
      memory_valid <= grant && in_range;
      if (grant && in_range) mreq <= win;
    end
  end
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prefer_d <= 1'b1;
    else if (grant) prefer_d <= !pick_d;
  end
`else
  assign prefer_d = 1'b1;
`endif
  assign memory_instr = mreq.instr;
  assign memory_addr  = mreq.addr;
  assign memory_wdata = mreq.wdata;
  assign memory_wstrb = mreq.wstrb;
  a_spurious_ready: assert property (@(posedge clock) disable iff (reset) !(memory_ready && !busy))
    else $warning("bram_arbiter: memory_ready with no transaction outstanding, discarded");
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed self-checking bench for bram_arbiter (either priority build).
module tb_bram_arbiter;
  logic        clock = 1'b0, reset = 1'b1;
  logic        imem_valid, imem_instr, dmem_valid, dmem_instr, memory_ready;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata, memory_rdata;
  logic [3:0]  imem_wstrb, dmem_wstrb;
  logic [31:0] imem_rdata, dmem_rdata, memory_addr, memory_wdata;
  logic        imem_ready, dmem_ready, memory_valid, memory_instr;
  logic [3:0]  memory_wstrb;
  int          errors = 0, checks = 0;
  bit          rr;
  logic [31:0] first_addr, second_addr;
  bram_arbiter dut (
    .reset, .clock,
    .imem_valid, .imem_instr, .imem_addr, .imem_wdata, .imem_wstrb, .imem_rdata, .imem_ready,
    .dmem_valid, .dmem_instr, .dmem_addr, .dmem_wdata, .dmem_wstrb, .dmem_rdata, .dmem_ready,
    .memory_valid, .memory_instr, .memory_addr, .memory_wdata, .memory_wstrb,
    .memory_rdata, .memory_ready
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic smp();
    @(negedge clock);
  endtask
  task automatic idle_in();
    imem_valid = 0; imem_instr = 0; imem_addr = 0; imem_wdata = 0; imem_wstrb = 0;
    dmem_valid = 0; dmem_instr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    memory_ready = 0; memory_rdata = 0;
  endtask
  task automatic req_i(input logic [31:0] a);
    imem_valid = 1; imem_instr = 1; imem_addr = a; imem_wstrb = 0;
  endtask
  task automatic req_d(input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    dmem_valid = 1; dmem_instr = 0; dmem_addr = a; dmem_wstrb = s; dmem_wdata = w;
  endtask
  task automatic respond(input logic [31:0] d);
    idle_in(); memory_ready = 1; memory_rdata = d;
  endtask
  task automatic local_d(input logic [31:0] a, input string tag);
    step(); req_d(a, 4'hF, 32'hCAFE_F00D);
    step(); idle_in(); smp();
    check({tag, "_no_mvalid"}, memory_valid, 0);
    check({tag, "_dready"}, dmem_ready, 1);
    check({tag, "_rdata0"}, dmem_rdata, 0);
    step(); smp();
    check({tag, "_dready_pulse"}, dmem_ready, 0);
  endtask
  task automatic rr_run(input string tag);
    logic mv = 0;
    bit   exp_d = 1;
    step(); req_i(32'h600); req_d(32'h700, 0, 0); smp();
    for (int c = 0; c < 30; c++) begin
      step(); memory_ready = mv; memory_rdata = c; #1;
      imem_valid = imem_ready; dmem_valid = dmem_ready; smp();
      if (memory_valid) begin
        check(tag, memory_addr, exp_d ? 32'h700 : 32'h600);
        exp_d = rr ? !exp_d : 1'b1;
      end
      mv = memory_valid;
    end
    step(); idle_in(); reset = 1;
    step(); reset = 0;
  endtask
  initial begin
`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
    rr = 1;
`else
    rr = 0;
`endif
    idle_in();
    repeat (2) step();
    smp();
    check("rst_mvalid", memory_valid, 0);
    check("rst_maddr", memory_addr, 0);
    check("rst_iready", imem_ready, 0);
    check("rst_dready", dmem_ready, 0);
    step(); reset = 0;
    // instruction read, RAM answers two cycles after memory_valid
    step(); req_i(32'h100); smp();
    check("i_lat0", memory_valid, 0);
    step(); idle_in(); smp();
    check("i_mvalid", memory_valid, 1);
    check("i_maddr", memory_addr, 32'h100);
    check("i_mwstrb", memory_wstrb, 0);
    check("i_minstr", memory_instr, 1);
    step(); smp();
    check("i_mvalid_pulse", memory_valid, 0);
    step(); respond(32'hDEAD_BEEF); smp();
    check("i_iready", imem_ready, 1);
    check("i_irdata", imem_rdata, 32'hDEAD_BEEF);
    check("i_dready", dmem_ready, 0);
    check("i_hold", memory_addr, 32'h100);
    step(); idle_in(); smp();
    check("i_iready_pulse", imem_ready, 0);
    // same-cycle conflict, D wins first in both builds here
    step(); req_i(32'h200); req_d(32'h300, 4'hF, 32'h1234_5678);
    step(); idle_in(); smp();
    check("c_first_addr", memory_addr, 32'h300);
    check("c_first_wstrb", memory_wstrb, 4'hF);
    check("c_first_wdata", memory_wdata, 32'h1234_5678);
    step(); respond(32'h0); smp();
    check("c_dready", dmem_ready, 1);
    check("c_iready0", imem_ready, 0);
    step(); idle_in(); smp();
    check("c_second_mvalid", memory_valid, 1);
    check("c_second_addr", memory_addr, 32'h200);
    check("c_dready_once", dmem_ready, 0);
    step(); respond(32'h1111_2222); smp();
    check("c_iready", imem_ready, 1);
    check("c_irdata", imem_rdata, 32'h1111_2222);
    step(); idle_in(); smp();
    check("c_idle", memory_valid, 0);
    check("c_iready_once", imem_ready, 0);
    // out-of-range requests answered locally; top of window still forwarded
    $display("out-of-range D request at addr %h", 32'h0100_0000);
    local_d(32'h0100_0000, "oor_far");
    local_d(32'h0010_0000, "oor_top");
    step(); req_d(32'h000F_FFFF, 0, 0);
    step(); idle_in(); smp();
    check("top1_mvalid", memory_valid, 1);
    check("top1_maddr", memory_addr, 32'h000F_FFFF);
    step(); respond(32'h5555_AAAA); smp();
    check("top1_drdata", dmem_rdata, 32'h5555_AAAA);
    step(); idle_in();
    // second conflict: round-robin now favours I after the run of D grants
    first_addr  = rr ? 32'h200 : 32'h300;
    second_addr = rr ? 32'h300 : 32'h200;
    step(); req_i(32'h200); req_d(32'h300, 4'hF, 32'h1234_5678);
    step(); idle_in(); smp();
    check("c2_first", memory_addr, first_addr);
    step(); respond(32'h7); smp();
    check("c2_first_iready", imem_ready, rr ? 1 : 0);
    check("c2_first_dready", dmem_ready, rr ? 0 : 1);
    step(); idle_in(); smp();
    check("c2_second", memory_addr, second_addr);
    step(); respond(32'h8); smp();
    check("c2_second_iready", imem_ready, rr ? 0 : 1);
    step(); idle_in();
    // new D request in the cycle of its own response
    step(); req_d(32'h400, 0, 0);
    step(); idle_in(); smp();
    check("own_first", memory_addr, 32'h400);
    step(); respond(32'hAB); req_d(32'h404, 0, 0); smp();
    check("own_dready", dmem_ready, 1);
    step(); idle_in(); smp();
    check("own_mvalid", memory_valid, 1);
    check("own_addr", memory_addr, 32'h404);
    step(); respond(32'hCD); smp();
    check("own_dready2", dmem_ready, 1);
    check("own_drdata2", dmem_rdata, 32'hCD);
    step(); idle_in(); smp();
    check("own_done", memory_valid, 0);
    // reset while BUSY_I, then a late memory_ready
    step(); req_i(32'h500);
    step(); idle_in(); smp();
    check("rm_busy", memory_valid, 1);
    step(); reset = 1; smp();
    check("rm_mvalid", memory_valid, 0);
    check("rm_maddr", memory_addr, 0);
    check("rm_iready", imem_ready, 0);
    step(); reset = 0;
    step(); respond(32'h9999_9999); smp();
    check("rm_late_iready", imem_ready, 0);
    check("rm_late_irdata", imem_rdata, 0);
    check("rm_late_dready", dmem_ready, 0);
    step(); idle_in(); smp();
    check("rm_idle", memory_valid, 0);
    // both requesters always requesting
    rr_run(rr ? "rr_alternate" : "fixed_d_first");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single block-RAM memory port between the instruction-fetch requester (I) and the load/store requester (D).
- Captures one request per requester, grants one at a time and drives the bram memory interface.
- Routes each response back to its owner.
- Requests outside [BRAM_BASE, BRAM_TOP) never reach the RAM; they are answered locally with zero data.

Parameters:
- BRAM_BASE, 32'h000000: inclusive low bound of the bram window (matches bram_base_addr).
- BRAM_TOP, 32'h100000: exclusive high bound of the bram window (matches bram_top_addr).

Ports:
- reset  in  1  asynchronous, active-high reset.
- clock  in  1  single clock; all state is on its rising edge.
- imem_valid  in  1  I request pulse, one cycle.
- imem_instr  in  1  instruction-fetch flag, forwarded to the RAM.
- imem_addr  in  32  I byte address.
- imem_wdata  in  32  I write data (normally unused).
- imem_wstrb  in  4  I byte write strobes; 0 means read.
- imem_rdata  out  32  I read data, valid while imem_ready is high.
- imem_ready  out  1  I response pulse, one cycle.
- dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb, dmem_rdata, dmem_ready: same widths and meaning for D.
- memory_valid  out  1  request pulse to the bram.
- memory_instr  out  1  forwarded instruction flag.
- memory_addr  out  32  forwarded address.
- memory_wdata  out  32  forwarded write data.
- memory_wstrb  out  4  forwarded strobes.
- memory_rdata  in  32  bram read data.
- memory_ready  in  1  bram response pulse.

Behaviour:
- Reset values: all outputs 0; state IDLE; both pending slots empty; the round-robin pointer, when present, selects D.

Capture:
- A requester's valid pulse loads {instr, addr, wdata, wstrb} into that requester's slot and sets its pending bit on the next edge.
- Each requester has at most one outstanding request.
- A valid while the slot is pending is a protocol violation: it is ignored and an assertion fires.
- A valid in the same cycle as that requester's ready is legal and is captured.

State machine (IDLE, BUSY_I, BUSY_D, LOCAL_I, LOCAL_D):
- IDLE to grant:
  - A requester is eligible when its pending bit is set or its valid is high in that cycle.
  - The captured request is used if pending, otherwise the live inputs.
- IDLE to BUSY_x (winner x, in-range address):
  - On the next edge memory_valid pulses for exactly one cycle with the winner's fields.
  - Request-to-memory_valid latency is 1 cycle.
- IDLE to LOCAL_x (out-of-range address: addr < BRAM_BASE or addr >= BRAM_TOP, unsigned 32-bit compare):
  - No memory_valid is issued.
  - x_ready pulses with x_rdata = 0 in the cycle after the grant.
  - Writes are dropped.
  - Then return to IDLE.
- BUSY_x:
  - memory_* fields are held stable.
  - On memory_ready, x_ready = 1 and x_rdata = memory_rdata combinationally in the same cycle.
  - The other requester's ready stays 0.
  - x's pending bit clears; next state is IDLE.
- Back-to-back: when IDLE is re-entered with the other requester pending, its memory_valid appears in the cycle after the previous memory_ready, so there is no idle bubble beyond one cycle.

Arbitration:
- Default is fixed priority, D over I, when both are eligible in the same IDLE cycle.
- A losing request stays pending and is never lost.

Boundary cases:
- memory_ready in IDLE or LOCAL_x (spurious) is discarded and an assertion fires.
- Reset mid-transaction clears state and slots immediately; a late memory_ready after reset is discarded.
- Address BRAM_TOP-1 is in range; address BRAM_TOP is local.

Optional Feature:
- Macro: BRAM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant pointer toggles priority.
  - On a same-cycle conflict, the requester not granted last wins.
  - The pointer updates on each grant, including local grants.
  - Starvation bound: each requester waits at most one foreign transaction.
- Undefined: fixed D-over-I priority, as above, with no pointer register.

Decomposition:
- The existing configure package gains typedef mem_req_t {instr, addr[31:0], wdata[31:0], wstrb[3:0]} and an enum arb_state_t for the five states.
- The bram window bounds come from bram_base_addr and bram_top_addr.
- One sub-module, bram_arbiter_slot, instantiated twice: capture register plus pending bit, with inputs valid, req, clear and outputs pending, req_q.

Test Plan:
- I read only: imem_valid pulse at addr 0x100, RAM answers 2 cycles after memory_valid with 0xDEADBEEF → memory_valid 1 cycle after request with memory_addr 0x100 and memory_wstrb 0; imem_ready with imem_rdata 0xDEADBEEF in the memory_ready cycle; dmem_ready stays 0.
- Conflict: I addr 0x200 and D write addr 0x300, wstrb 4'hF, data 0x12345678 in the same cycle → D issued first; I issued the cycle after D's memory_ready; both readies seen once each. With the macro, a second conflict grants I first.
- Out of range: dmem addr 0x1000000 (print) → no memory_valid; dmem_ready the cycle after the grant with rdata 0. Addr 0x0FFFFF is forwarded to the RAM.
- Request during own response: the D response cycle carries a new dmem_valid at addr 0x404 → captured; issued the next cycle; no request lost.
- Reset mid-op: assert reset while BUSY_I, then return memory_ready after release → all outputs 0, no imem_ready, assertion on the spurious ready.
- Starvation (macro defined): D requests every cycle alongside I → I granted at least every second transaction.
